// File: rtl/mult_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// State encoding, the default watchdog length and the grant-index width.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEFAULT_WDOG = 15;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request strictly after 'last', wrapping.
// Outputs a one-hot grant, its index, and whether any request is present.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    logic [NUM_REQ-1:0] above_last;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pool;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign above_last[gi] = (gi > int'(last));
        end
    endgenerate

    // Requests above the last grant win; otherwise wrap to the full vector.
    assign masked = req & above_last;
    assign pool   = (|masked) ? masked : req;
    assign any    = |req;

    // Lowest set bit of the pool.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pool[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier core among NUM_REQ requesters: round-robin accept,
// start pulse, watchdog-guarded wait for done, then a per-requester response.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 16,
    parameter int RES_W   = 32,
    parameter int WDOG    = DEFAULT_WDOG
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OP_W-1:0]   req_a,
    input  logic [NUM_REQ*OP_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [RES_W-1:0]          rsp_data,
    output logic                      rsp_err,
    input  logic                      abort,
    output logic                      mul_enable,
    output logic                      mul_start,
    output logic [OP_W-1:0]           mul_a,
    output logic [OP_W-1:0]           mul_b,
    input  logic                      mul_done,
    input  logic [RES_W-1:0]          mul_result,
    output logic                      busy,
    output logic [idx_w(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int WD_W  = $clog2(WDOG + 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   last_reg, last_next;
    logic [IDX_W-1:0]   grant_id_reg, grant_id_next;
    logic [OP_W-1:0]    mul_a_reg, mul_a_next;
    logic [OP_W-1:0]    mul_b_reg, mul_b_next;
    logic [RES_W-1:0]   rsp_data_reg, rsp_data_next;
    logic               rsp_err_reg, rsp_err_next;
    logic [WD_W-1:0]    wdog_reg, wdog_next;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [OP_W-1:0]    a_slice [NUM_REQ];
    logic [OP_W-1:0]    b_slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*OP_W +: OP_W];
            assign b_slice[gi] = req_b[gi*OP_W +: OP_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req_valid),
        .last    (last_reg),
        .gnt     (pick_onehot),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign grant_onehot = NUM_REQ'(1) << grant_id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            last_reg     <= IDX_W'(NUM_REQ - 1);
            grant_id_reg <= '0;
            mul_a_reg    <= '0;
            mul_b_reg    <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
            wdog_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            grant_id_reg <= grant_id_next;
            mul_a_reg    <= mul_a_next;
            mul_b_reg    <= mul_b_next;
            rsp_data_reg <= rsp_data_next;
            rsp_err_reg  <= rsp_err_next;
            wdog_reg     <= wdog_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        grant_id_next = grant_id_reg;
        mul_a_next    = mul_a_reg;
        mul_b_next    = mul_b_reg;
        rsp_data_next = rsp_data_reg;
        rsp_err_next  = rsp_err_reg;
        wdog_next     = wdog_reg;
        req_ready     = '0;
        rsp_valid     = '0;
        mul_enable    = 1'b0;
        mul_start     = 1'b0;
        busy          = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                // Held low during reset so no requester sees a spurious accept.
                req_ready = rst_n ? pick_onehot : '0;
                if (pick_any) begin
                    mul_a_next    = a_slice[pick_idx];
                    mul_b_next    = b_slice[pick_idx];
                    grant_id_next = pick_idx;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                mul_enable = 1'b1;
                mul_start  = 1'b1;
                wdog_next  = WD_W'(WDOG);
                if (abort) begin
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b1;
                    state_next    = RESP;
                end else begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                mul_enable = 1'b1;
                wdog_next  = wdog_reg - WD_W'(1);
                // done beats abort, abort beats watchdog expiry.
                if (mul_done) begin
                    rsp_data_next = mul_result;
                    rsp_err_next  = 1'b0;
                    state_next    = RESP;
                end else if (abort || (wdog_reg == WD_W'(1))) begin
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b1;
                    state_next    = RESP;
                end
            end
            default: begin
                rsp_valid = grant_onehot;
                if (rsp_ready[grant_id_reg]) begin
                    last_next  = grant_id_reg;
                    state_next = IDLE;
                end
            end
        endcase
    end

    assign rsp_data = rsp_data_reg;
    assign rsp_err  = rsp_err_reg;
    assign mul_a    = mul_a_reg;
    assign mul_b    = mul_b_reg;
    assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: transaction-level reference model driven by cycle
// offsets from each accept, directed scenarios plus a long randomized run.
module tb_mult_arbiter;

    localparam int N    = 4;
    localparam int WDOG = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready = '0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        abort = 1'b0;
    logic        mul_enable;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_done = 1'b0;
    logic [31:0] mul_result = '0;
    logic        busy;
    logic [1:0]  grant_id;

    mult_arbiter #(.NUM_REQ(4), .OP_W(16), .RES_W(32), .WDOG(WDOG)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .abort(abort), .mul_enable(mul_enable), .mul_start(mul_start),
        .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_result(mul_result),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_ops = 0;

    // Reference model: one operation in flight, described by offsets from its accept.
    bit          m_active;
    int          m_acc, m_end_k, m_gid, m_last, m_lat;
    logic [15:0] m_a, m_b;
    logic [31:0] m_data;
    bit          m_err;
    int          grants[$];

    // Stimulus knobs.
    int lat_force  = -2;
    int abort_at   = -1;
    bit abort_rand = 1'b0;

    // Expected outputs for the current cycle.
    bit          chk_en = 1'b0;
    logic [3:0]  e_req_ready, e_rsp_valid;
    logic        e_busy, e_en, e_start, e_err, e_resp;
    logic [1:0]  e_gid;
    logic [15:0] e_a, e_b;
    logic [31:0] e_data;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [3:0] rv, input int last);
        for (int s = 1; s <= N; s++) begin
            int i;
            i = (last + s) % N;
            if (rv[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_acc = 0; m_end_k = -1; m_gid = 0; m_last = N - 1;
        m_lat = -1; m_a = '0; m_b = '0; m_data = '0; m_err = 1'b0;
    endtask

    task automatic drive_core();
        int k;
        k = cyc - m_acc;
        abort = (m_active && m_end_k < 0 && k == abort_at) ||
                (abort_rand && $urandom_range(0, 29) == 0);
        if (m_active && m_end_k < 0 && m_lat >= 0 && k == 1 + m_lat) begin
            mul_done   = 1'b1;
            mul_result = 32'(m_a) * 32'(m_b);
        end else if (m_active && m_end_k < 0 && k >= 2) begin
            mul_done   = 1'b0;
            mul_result = $urandom;
        end else begin
            // Stray pulses while no wait is in progress must be ignored.
            mul_done   = ($urandom_range(0, 7) == 0);
            mul_result = $urandom;
        end
    endtask

    task automatic model_expect();
        int k, p;
        k = cyc - m_acc;
        p = pick(req_valid, m_last);
        e_resp      = m_active && m_end_k >= 0 && k > m_end_k;
        e_busy      = m_active;
        e_req_ready = (!m_active && p >= 0) ? 4'(1 << p) : 4'b0;
        e_en        = m_active && !e_resp;
        e_start     = m_active && k == 1;
        e_rsp_valid = e_resp ? 4'(1 << m_gid) : 4'b0;
        e_gid       = 2'(m_gid);
        e_a         = m_a;
        e_b         = m_b;
        e_data      = m_data;
        e_err       = m_err;
    endtask

    task automatic model_update();
        int k, p;
        k = cyc - m_acc;
        p = pick(req_valid, m_last);
        if (!m_active) begin
            if (p >= 0) begin
                m_active = 1'b1; m_acc = cyc; m_end_k = -1; m_gid = p;
                m_a = req_a[p*16 +: 16];
                m_b = req_b[p*16 +: 16];
                if (lat_force != -2) m_lat = lat_force;
                else if ($urandom_range(0, 9) < 2) m_lat = -1;
                else m_lat = $urandom_range(2, 16);
                grants.push_back(p);
            end
        end else if (m_end_k < 0) begin
            if (k >= 2 && mul_done) begin
                m_end_k = k; m_data = mul_result; m_err = 1'b0;
            end else if (abort) begin
                m_end_k = k; m_data = '0; m_err = 1'b1;
            end else if (k == WDOG + 1) begin
                m_end_k = k; m_data = '0; m_err = 1'b1;
            end
        end else if (k > m_end_k && rsp_ready[m_gid]) begin
            $display("op %0d: req=%0d a=%h b=%h data=%h err=%0d lat=%0d", n_ops, m_gid,
                     m_a, m_b, m_data, m_err, k);
            n_ops++;
            m_active = 1'b0;
            m_last   = m_gid;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("req_ready", 64'(req_ready), 64'(e_req_ready));
            cmp("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
            cmp("busy", 64'(busy), 64'(e_busy));
            cmp("mul_enable", 64'(mul_enable), 64'(e_en));
            cmp("mul_start", 64'(mul_start), 64'(e_start));
            cmp("grant_id", 64'(grant_id), 64'(e_gid));
            cmp("mul_a", 64'(mul_a), 64'(e_a));
            cmp("mul_b", 64'(mul_b), 64'(e_b));
            if (e_resp) begin
                cmp("rsp_data", 64'(rsp_data), 64'(e_data));
                cmp("rsp_err", 64'(rsp_err), 64'(e_err));
            end
        end
    end

    task automatic tick_a();
        drive_core();
        model_expect();
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick_b();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic tick();
        tick_a();
        tick_b();
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        req_valid = '0; rsp_ready = '0; abort = 1'b0; mul_done = 1'b0;
        mul_result = '0; req_a = '0; req_b = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        grants.delete();
    endtask

    task automatic drive_random();
        req_valid = 4'($urandom_range(0, 15));
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        rsp_ready = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

        // Reset state.
        do_reset();
        @(negedge clk);
        cmp("rst_busy", 64'(busy), 64'd0);
        cmp("rst_enable", 64'(mul_enable), 64'd0);
        cmp("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        cmp("rst_rsp_data", 64'(rsp_data), 64'd0);
        cmp("rst_grant_id", 64'(grant_id), 64'd0);
        @(posedge clk);
        #1;

        // Single request with a 6-cycle core.
        do_reset();
        lat_force = 6; abort_at = -1; abort_rand = 1'b0;
        rsp_ready = 4'hF;
        for (int t = 0; t < 10; t++) begin
            req_valid = (t == 0) ? 4'b0001 : 4'b0000;
            req_a = 64'h0000_0000_0000_00FF;
            req_b = 64'h0000_0000_0000_0010;
            tick_a();
            if (t == 0) cmp("t1_req_ready", 64'(req_ready), 64'h1);
            if (t == 1) cmp("t1_start", 64'(mul_start), 64'h1);
            if (t == 7) cmp("t1_rsp_early", 64'(rsp_valid), 64'h0);
            if (t == 8) begin
                cmp("t1_rsp_valid", 64'(rsp_valid), 64'h1);
                cmp("t1_rsp_data", 64'(rsp_data), 64'h0000_0FF0);
                cmp("t1_rsp_err", 64'(rsp_err), 64'h0);
            end
            if (t == 9) cmp("t1_idle", 64'(busy), 64'h0);
            tick_b();
        end

        // Fairness with every requester asserting.
        do_reset();
        lat_force = 6;
        req_valid = 4'hF; rsp_ready = 4'hF;
        for (int t = 0; t < 200 && grants.size() < 8; t++) tick();
        cmp("fair_count", 64'(grants.size()), 64'd8);
        for (int j = 0; j < 8 && j < grants.size(); j++)
            cmp("fair_order", 64'(grants[j]), 64'(exp_order[j]));
        req_valid = '0;
        for (int t = 0; t < 12; t++) tick();

        // Back-pressure, with non-granted rsp_ready lines asserted.
        do_reset();
        lat_force = 6;
        req_a = 64'h0000_1234_0000_0000;
        req_b = 64'h0000_0100_0000_0000;
        for (int t = 0; t < 15; t++) begin
            req_valid = (t == 0) ? 4'b0100 : 4'b1111;
            rsp_ready = (t == 13) ? 4'b0100 : 4'b1011;
            tick_a();
            if (t == 0) cmp("bp_accept", 64'(req_ready), 64'b0100);
            if (t >= 8 && t <= 13) begin
                cmp("bp_rsp_valid", 64'(rsp_valid), 64'b0100);
                cmp("bp_rsp_data", 64'(rsp_data), 64'h0012_3400);
                cmp("bp_grant_id", 64'(grant_id), 64'd2);
                cmp("bp_req_ready", 64'(req_ready), 64'd0);
            end
            if (t == 14) cmp("bp_next_accept", 64'(req_ready), 64'b1000);
            tick_b();
        end
        req_valid = '0; rsp_ready = 4'hF;
        for (int t = 0; t < 12; t++) tick();

        // Watchdog: core never completes.
        do_reset();
        lat_force = -1;
        for (int t = 0; t < 20; t++) begin
            req_valid = (t == 0) ? 4'b0001 : 4'b0000;
            rsp_ready = (t >= 18) ? 4'hF : 4'h0;
            tick_a();
            if (t == 16) begin
                cmp("wd_not_yet", 64'(rsp_valid), 64'h0);
                cmp("wd_enable_busy", 64'(mul_enable), 64'h1);
            end
            if (t == 17) begin
                cmp("wd_rsp_valid", 64'(rsp_valid), 64'h1);
                cmp("wd_rsp_err", 64'(rsp_err), 64'h1);
                cmp("wd_rsp_data", 64'(rsp_data), 64'h0);
                cmp("wd_enable_resp", 64'(mul_enable), 64'h0);
            end
            tick_b();
        end

        // done and abort in the same BUSY cycle: done wins.
        do_reset();
        lat_force = 4; abort_at = 5;
        rsp_ready = 4'hF;
        req_a = 64'h0000_0000_0000_00FF;
        req_b = 64'h0000_0000_0000_0010;
        for (int t = 0; t < 9; t++) begin
            req_valid = (t == 0) ? 4'b0001 : 4'b0000;
            tick_a();
            if (t == 6) begin
                cmp("col_rsp_valid", 64'(rsp_valid), 64'h1);
                cmp("col_rsp_err", 64'(rsp_err), 64'h0);
                cmp("col_rsp_data", 64'(rsp_data), 64'h0FF0);
            end
            tick_b();
        end

        // Abort alone in the third BUSY cycle.
        do_reset();
        lat_force = 6; abort_at = 4;
        rsp_ready = 4'hF;
        for (int t = 0; t < 8; t++) begin
            req_valid = (t == 0) ? 4'b0001 : 4'b0000;
            tick_a();
            if (t == 5) begin
                cmp("abt_rsp_valid", 64'(rsp_valid), 64'h1);
                cmp("abt_rsp_err", 64'(rsp_err), 64'h1);
                cmp("abt_rsp_data", 64'(rsp_data), 64'h0);
            end
            tick_b();
        end
        abort_at = -1;

        // Reset while BUSY.
        do_reset();
        lat_force = 6;
        for (int t = 0; t < 4; t++) begin
            req_valid = (t == 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        chk_en = 1'b0;
        req_valid = 4'hF;
        rst_n = 1'b0;
        #1;
        cmp("mid_rst_busy", 64'(busy), 64'h0);
        cmp("mid_rst_enable", 64'(mul_enable), 64'h0);
        cmp("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        cmp("mid_rst_req_ready", 64'(req_ready), 64'h0);
        do_reset();
        req_valid = 4'b1000;
        tick_a();
        cmp("post_rst_accept", 64'(req_ready), 64'b1000);
        tick_b();
        cmp("post_rst_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'd3);
        req_valid = '0; rsp_ready = 4'hF;
        for (int t = 0; t < 12; t++) tick();

        // Randomized traffic.
        do_reset();
        lat_force = -2; abort_rand = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            drive_random();
            tick();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one hex multiplier core (six-step compute, `done` pulse) between NUM_REQ requesters.
- Selects a requester by round-robin and latches its operands.
- Drives the core's enable/start, waits for `done` under a watchdog, then returns the product to the granted requester with a valid/ready handshake.
- Sits between the requester blocks and the multiplier top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- OP_W, 16, operand width in bits (4 hex digits)
- RES_W, 32, product width in bits
- WDOG, 15, max cycles in BUSY before the operation is declared failed

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_a  in  NUM_REQ*OP_W  packed operand A, requester i at [i*OP_W +: OP_W]
- req_b  in  NUM_REQ*OP_W  packed operand B
- req_ready  out  NUM_REQ  one-hot accept
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  RES_W  product, shared by all requesters
- rsp_err  out  1  response is a timeout/abort failure
- abort  in  1  synchronous cancel of the in-flight operation
- mul_enable  out  1  core enable; low forces core to idle
- mul_start  out  1  one-cycle start pulse
- mul_a, mul_b  out  OP_W  latched operands to core
- mul_done  in  1  core completion pulse
- mul_result  in  RES_W  core product, valid when mul_done=1
- busy  out  1  state != IDLE
- grant_id  out  clog2(NUM_REQ)  index of current/last grant

Behaviour:
- Reset state: IDLE. All outputs 0. Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - Winner g = first i with req_valid[i]=1, searching last+1, last+2, … with wrap modulo NUM_REQ.
  - req_ready[g]=1 combinationally in IDLE only; all other req_ready are 0.
  - Handshake (valid & ready) latches req_a/req_b of g into mul_a/mul_b, registers g into grant_id, and moves to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE (1 cycle): mul_enable=1, mul_start=1, watchdog loaded with WDOG, then BUSY.
- BUSY: mul_enable=1, mul_start=0, watchdog decrements every cycle.
  - mul_done=1: capture mul_result into rsp_data, rsp_err=0, go to RESP.
  - Watchdog reaches 0 without done: rsp_data=0, rsp_err=1, go to RESP.
  - abort=1 in ISSUE or BUSY: rsp_data=0, rsp_err=1, go to RESP. abort in IDLE or RESP is ignored.
- Priority in the same cycle: mul_done > abort > watchdog expiry.
- RESP:
  - mul_enable=0, which aborts/idles the core.
  - rsp_valid[grant_id]=1, held with rsp_data/rsp_err stable until rsp_ready[grant_id]=1.
  - rsp_ready on non-granted lines is ignored.
  - On handshake: last <= grant_id, rsp_valid -> 0, go to IDLE. A new request can be accepted the next cycle.
- mul_done outside BUSY is ignored.
- Latency with a 6-cycle core and rsp_ready held high: accept at cycle 0, start at cycle 1, done at cycle 7, rsp_valid at cycle 8, next accept at cycle 9.
- Requests are non-preemptive. A requester may drop req_valid before it is granted without side effect.
- Async reset mid-operation returns to the reset state immediately; the core is idled via mul_enable=0.
- grant_id and mul_a/mul_b hold their last values in IDLE.

Decomposition:
- Package mult_arb_pkg:
  - state encoding IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2, RESP=2'd3
  - default WDOG
  - grant-index width function
- Sub-module rr_arbiter:
  - combinational round-robin pick from a request vector and last-grant index
  - outputs a one-hot grant vector and its index
  - parameterised by NUM_REQ

Test Plan:
- Single request: req_valid=4'b0001, a=16'h00FF, b=16'h0010, core model returns 32'h0000_0FF0 after 6 cycles → req_ready[0] at cycle 0, mul_start at cycle 1, rsp_valid=4'b0001 with rsp_data=32'h0FF0 and rsp_err=0 at cycle 8.
- Fairness: req_valid=4'b1111 held for 8 operations → grant order 0,1,2,3,0,1,2,3.
- Back-pressure: rsp_ready low for 5 cycles in RESP → rsp_valid, rsp_data and grant_id stable; req_ready stays 0; accept occurs only after rsp_ready[g]=1.
- Watchdog: core never pulses done → rsp_valid after ISSUE+WDOG cycles with rsp_err=1 and rsp_data=0; mul_enable=0 in RESP.
- Abort/done collision: abort and mul_done in the same BUSY cycle → rsp_err=0, rsp_data=mul_result. Abort alone at the 3rd BUSY cycle → rsp_err=1.
- Reset mid-BUSY: rst_n low → busy, mul_enable, rsp_valid and req_ready all 0 immediately; after release, req_valid=4'b1000 is granted as the first operation.
